// File: rtl/fir_mdc_engine_if.sv
// Sample/result stream pair between the FIR streamer and the compute engine.
// The engine takes the slave side; the streamer (or a bench) takes the master side.
interface fir_mdc_engine_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  x_valid;
    logic                  x_ready;
    logic [DATA_WIDTH-1:0] x_data;
    logic                  y_valid;
    logic                  y_ready;
    logic [DATA_WIDTH-1:0] y_data;

    modport master (
        output x_valid, x_data, y_ready,
        input  x_ready, y_valid, y_data
    );

    modport slave (
        input  x_valid, x_data, y_ready,
        output x_ready, y_valid, y_data
    );
endinterface

// File: rtl/fir_mdc_engine.sv
// Streaming direct-form FIR engine: one saturated, shifted output per accepted
// sample, single-entry output buffer, programmable job length with done pulse.
module fir_mdc_engine #(
    parameter int NTAPS       = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int COEFF_WIDTH = 16,
    parameter int ACC_WIDTH   = 36
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         enable_i,
    input  logic                         start_i,
    input  logic [31:0]                  len_i,
    input  logic [4:0]                   shift_i,
    input  logic [NTAPS*COEFF_WIDTH-1:0] coeff_i,
    fir_mdc_engine_if.slave              stream,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [31:0]                  cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32'sd32767);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32'sd32768);

    state_t                        state_q, state_d;
    logic signed [COEFF_WIDTH-1:0] coeff_q [NTAPS];
    logic signed [15:0]            dly_q   [NTAPS-1];
    logic [4:0]                    shift_q;
    logic [31:0]                   len_q, in_cnt_q, cnt_q, cnt_d;
    logic                          y_valid_q;
    logic [DATA_WIDTH-1:0]         y_data_q, y_next;
    logic                          x_ready, x_fire, y_fire;
    logic signed [15:0]            sample, sat;
    logic signed [ACC_WIDTH-1:0]   acc, shifted;
    logic                          unused_upper;

    assign sample       = stream.x_data[15:0];
    assign unused_upper = ^stream.x_data[DATA_WIDTH-1:16];

    assign x_ready = enable_i && (state_q == RUN) && (in_cnt_q < len_q)
                     && (!y_valid_q || stream.y_ready);
    assign x_fire  = stream.x_valid && x_ready;
    assign y_fire  = enable_i && y_valid_q && stream.y_ready;
    assign cnt_d   = y_fire ? cnt_q + 32'd1 : cnt_q;

    assign stream.x_ready = x_ready;
    assign stream.y_valid = y_valid_q;
    assign stream.y_data  = y_data_q;
    assign busy_o         = (state_q == RUN) || (state_q == FLUSH);
    assign done_o         = (state_q == DONE);
    assign cnt_o          = cnt_q;

    // Tap 0 uses the incoming sample; older taps use the delay line before the shift.
    always_comb begin
        acc = ACC_WIDTH'(sample) * ACC_WIDTH'(coeff_q[0]);
        for (int k = 1; k < NTAPS; k++) begin
            acc = acc + ACC_WIDTH'(dly_q[k-1]) * ACC_WIDTH'(coeff_q[k]);
        end
        shifted = acc >>> shift_q;
        if (shifted > SAT_MAX)      sat = 16'sh7fff;
        else if (shifted < SAT_MIN) sat = -16'sh8000;
        else                        sat = shifted[15:0];
        y_next = {{(DATA_WIDTH-16){sat[15]}}, sat};
    end

    always_comb begin
        // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (len_i == 32'd0) ? DONE : RUN;
            RUN:     if (x_fire && (in_cnt_q + 32'd1 == len_q)) state_d = FLUSH;
            FLUSH:   if (cnt_d == len_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: the delay line and coefficient latch are explicitly reset; the spec
        // requires zeroed filter state, so these arrays cannot be left as raw RAM.
        if (rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            len_q     <= '0;
            in_cnt_q  <= '0;
            cnt_q     <= '0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            for (int k = 0; k < NTAPS; k++)   coeff_q[k] <= '0;
            for (int k = 0; k < NTAPS-1; k++) dly_q[k]   <= '0;
        end else if (clear_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            len_q     <= '0;
            in_cnt_q  <= '0;
            cnt_q     <= '0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            for (int k = 0; k < NTAPS; k++)   coeff_q[k] <= '0;
            for (int k = 0; k < NTAPS-1; k++) dly_q[k]   <= '0;
        end else if (enable_i) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && start_i) begin
                shift_q  <= shift_i;
                len_q    <= len_i;
                in_cnt_q <= '0;
                cnt_q    <= '0;
                for (int k = 0; k < NTAPS; k++)
                    coeff_q[k] <= coeff_i[k*COEFF_WIDTH +: COEFF_WIDTH];
                for (int k = 0; k < NTAPS-1; k++) dly_q[k] <= '0;
            end
            if (x_fire) begin
                dly_q[0] <= sample;
                for (int k = 1; k < NTAPS-1; k++) dly_q[k] <= dly_q[k-1];
                y_data_q  <= y_next;
                in_cnt_q  <= in_cnt_q + 32'd1;
                y_valid_q <= 1'b1;
            end else if (y_fire) begin
                y_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_mdc_engine.sv
// Self-checking bench for fir_mdc_engine: directed cases plus randomized jobs
// checked against a convolution model of the filter.
module tb_fir_mdc_engine;
    localparam int NT = 4;

    logic             clk = 1'b0;
    logic             rst, clear, enable, start;
    logic [31:0]      len;
    logic [4:0]       shift;
    logic [NT*16-1:0] coeff;
    logic             busy, done;
    logic [31:0]      cnt;

    fir_mdc_engine_if #(.DATA_WIDTH(32)) bus ();

    fir_mdc_engine #(.NTAPS(NT), .DATA_WIDTH(32), .COEFF_WIDTH(16), .ACC_WIDTH(36)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable), .start_i(start),
        .len_i(len), .shift_i(shift), .coeff_i(coeff), .stream(bus),
        .busy_o(busy), .done_o(done), .cnt_o(cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic signed [15:0] cf [NT];
    int                 sh;
    logic [31:0]        xs [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output n of the job: zero-initial-condition convolution, floor shift, 16-bit clamp.
    function automatic logic [31:0] ref_y(input int n);
        longint acc = 0;
        for (int k = 0; k < NT; k++)
            if (n - k >= 0)
                acc += longint'(signed'(xs[n-k][15:0])) * longint'(cf[k]);
        acc = acc >>> sh;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc[31:0];
    endfunction

    task automatic kick(input int n);
        @(negedge clk);
        for (int k = 0; k < NT; k++) coeff[k*16 +: 16] = cf[k];
        len         = n;
        shift       = 5'(sh);
        start       = 1'b1;
        enable      = 1'b1;
        bus.x_valid = 1'b0;
        bus.y_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random. en_mode 1: enable low 5 cycles.
    task automatic run_job(input int rdy_mode, input int en_mode, input bit vrand);
        int          n = xs.size();
        int          xi = 0, yi = 0, cyc = 0;
        bit          stall = 0, finished = 0, xfire, yfire;
        logic [31:0] prev_y = '0;
        kick(n);
        if (n == 0) begin
            @(negedge clk); #1;
            check("len0_done", 32'(done), 32'd1);
            check("len0_busy", 32'(busy), 32'd0);
            check("len0_xrdy", 32'(bus.x_ready), 32'd0);
            check("len0_yvld", 32'(bus.y_valid), 32'd0);
            @(negedge clk); #1;
            check("len0_done_pulse", 32'(done), 32'd0);
            return;
        end
        while (!finished && cyc < 400) begin
            @(negedge clk);
            if (yi == n) begin
                #1;
                check("done_high", 32'(done), 32'd1);
                check("cnt_final", cnt, 32'(n));
                check("busy_end", 32'(busy), 32'd0);
                finished = 1;
            end else begin
                enable      = (en_mode == 1) ? !(cyc >= 3 && cyc < 8) : 1'b1;
                bus.y_ready = (rdy_mode == 0) ? 1'b1 :
                              (rdy_mode == 1) ? (cyc % 4 == 0 || cyc % 4 == 3) :
                              ($urandom_range(0, 3) != 0);
                bus.x_valid = (xi < n) && (vrand ? ($urandom_range(0, 2) != 0) : 1'b1);
                bus.x_data  = (xi < n) ? xs[xi] : 32'h0;
                #1;
                if (cyc == 0) check("busy_run", 32'(busy), 32'd1);
                if (stall) begin
                    check("y_hold_data", bus.y_data, prev_y);
                    check("y_hold_valid", 32'(bus.y_valid), 32'd1);
                end
                if (!enable) check("x_ready_disabled", 32'(bus.x_ready), 32'd0);
                if (bus.y_valid && !bus.y_ready)
                    check("x_ready_full", 32'(bus.x_ready), 32'd0);
                xfire = bus.x_valid && bus.x_ready;
                yfire = enable && bus.y_valid && bus.y_ready;
                if (yfire) begin
                    if (yi < n) begin
                        check($sformatf("y[%0d]", yi), bus.y_data, ref_y(yi));
                        check("cnt_run", cnt, 32'(yi));
                    end else begin
                        check("extra_y", 32'(yi), 32'(n));
                    end
                    yi++;
                end
                if (xfire) xi++;
                stall  = bus.y_valid && !yfire && !xfire;
                prev_y = bus.y_data;
                cyc++;
            end
        end
        bus.x_valid = 1'b0;
        enable      = 1'b1;
        if (!finished) check("job_timeout", 32'd0, 32'd1);
        @(negedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic set_case1();
        cf = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        sh = 0;
        xs = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; enable = 1'b1; start = 1'b0;
        len = '0; shift = '0; coeff = '0;
        bus.x_valid = 1'b0; bus.x_data = '0; bus.y_ready = 1'b0;
        #2;
        check("rst_xrdy", 32'(bus.x_ready), 32'd0);
        check("rst_yvld", 32'(bus.y_valid), 32'd0);
        check("rst_ydata", bus.y_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", cnt, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Impulse response, then backpressure, then enable stall.
        set_case1(); run_job(0, 0, 0);
        set_case1(); run_job(1, 0, 0);
        set_case1(); run_job(0, 1, 0);

        // Saturation both ways, then floor shift of a negative value.
        cf = '{16'sh7fff, 16'sd0, 16'sd0, 16'sd0}; sh = 0;
        xs = '{32'h0000_7fff, 32'h0000_8000};
        run_job(0, 0, 0);
        cf = '{16'sd1, 16'sd0, 16'sd0, 16'sd0}; sh = 1;
        xs = '{32'h0000_fffd};
        run_job(0, 0, 0);

        // Zero-length job.
        xs = {};
        run_job(0, 0, 0);

        // Soft clear after 3 of 8 samples, then a fresh impulse job.
        cf = '{16'sd1, 16'sd2, 16'sd3, 16'sd4}; sh = 0;
        kick(8);
        repeat (3) begin
            @(negedge clk);
            bus.x_valid = 1'b1; bus.y_ready = 1'b1; bus.x_data = $urandom();
        end
        @(negedge clk);
        clear = 1'b1; bus.x_valid = 1'b0;
        @(posedge clk); #1 clear = 1'b0;
        check("clr_yvld", 32'(bus.y_valid), 32'd0);
        check("clr_cnt", cnt, 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        xs = '{32'd1, 32'd0, 32'd0, 32'd0};
        run_job(0, 0, 0);

        // Asynchronous reset mid-job with a pending output.
        kick(10);
        repeat (3) begin
            @(negedge clk);
            bus.x_valid = 1'b1; bus.y_ready = 1'b1; bus.x_data = 32'd7;
        end
        @(negedge clk) bus.y_ready = 1'b0;
        @(posedge clk); #3;
        check("pre_rst_yvld", 32'(bus.y_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_yvld", 32'(bus.y_valid), 32'd0);
        check("arst_ydata", bus.y_data, 32'd0);
        check("arst_cnt", cnt, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_xrdy", 32'(bus.x_ready), 32'd0);
        bus.x_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        set_case1(); run_job(0, 0, 0);

        // Randomized jobs with random valid/ready.
        repeat (8) begin
            for (int k = 0; k < NT; k++) cf[k] = 16'($urandom());
            sh = $urandom_range(0, 20);
            xs = {};
            repeat ($urandom_range(1, 24)) xs.push_back($urandom());
            run_job(2, 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
